// File: rtl/get_digests_requester.sv
// get_digests_requester: issues a GET_DIGESTS request, captures the DIGESTS answer,
// validates its header and reports either the digests or an error code, retrying on timeout.
module get_digests_requester #(
  parameter int HDR_W = 32,
  parameter int PAY_W = 96,
  parameter logic [7:0] PROTO_VER = 8'h01,
  parameter logic [7:0] REQ_CMD = 8'h81,
  parameter logic [7:0] RSP_CMD = 8'h01,
  parameter int TIMEOUT = 255,
  parameter int MAX_RETRIES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [HDR_W-1:0] req_header,
  output logic             req_valid,
  input  logic             rsp_ack_in,
  input  logic [HDR_W-1:0] rsp_header,
  input  logic [PAY_W-1:0] rsp_payload,
  output logic [PAY_W-1:0] digests,
  output logic [7:0]       slot_mask,
  output logic             digests_valid,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE, ERR} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRIES);
  localparam logic [HDR_W-1:0] REQ_HDR = HDR_W'({PROTO_VER, REQ_CMD, 16'h0000});
  state_t state;
  logic [7:0] cnt;
  logic [7:0] retries;
  logic [HDR_W-1:0] hdr_q;
  logic [PAY_W-1:0] pay_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      retries <= '0;
      hdr_q <= '0;
      pay_q <= '0;
      req_header <= '0;
      req_valid <= 1'b0;
      digests <= '0;
      slot_mask <= '0;
      digests_valid <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= '0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SEND;
          busy <= 1'b1;
          req_header <= REQ_HDR;
          digests_valid <= 1'b0;
          err_code <= '0;
          retries <= '0;
        end
        SEND: begin
          cnt <= '0;
          req_valid <= 1'b1;
          state <= WAIT;
        end
        // ack takes priority over the timeout terminal count
        WAIT: if (rsp_ack_in) begin
          hdr_q <= rsp_header;
          pay_q <= rsp_payload;
          req_valid <= 1'b0;
          state <= CHECK;
        end else if (cnt == TMO) begin
          req_valid <= 1'b0;
          if (retries < RETRY_MAX) begin
            retries <= retries + 8'd1;
            state <= SEND;
          end else begin
            err_code <= 3'd4;
            error <= 1'b1;
            state <= ERR;
          end
        end else begin
          cnt <= cnt + 8'd1;
        end
        CHECK: if (hdr_q[31:24] != PROTO_VER) begin
          err_code <= 3'd1;
          error <= 1'b1;
          state <= ERR;
        end else if (hdr_q[23:16] != RSP_CMD) begin
          err_code <= 3'd2;
          error <= 1'b1;
          state <= ERR;
        end else if (hdr_q[7:0] == 8'h00) begin
          err_code <= 3'd3;
          error <= 1'b1;
          state <= ERR;
        end else begin
          digests <= pay_q;
          slot_mask <= hdr_q[7:0];
          digests_valid <= 1'b1;
          done <= 1'b1;
          state <= DONE;
        end
        DONE, ERR: begin
          state <= IDLE;
          busy <= 1'b0;
          req_header <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_get_digests_requester.sv
// tb_get_digests_requester: directed checks of the GET_DIGESTS requester with a short timeout.
module tb_get_digests_requester;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic rsp_ack_in = 1'b0;
  logic [31:0] rsp_header = '0;
  logic [95:0] rsp_payload = '0;
  logic [31:0] req_header;
  logic req_valid;
  logic [95:0] digests;
  logic [7:0] slot_mask;
  logic digests_valid, done, error, busy;
  logic [2:0] err_code;
  int total = 0;
  int bad = 0;
  localparam logic [95:0] PAY = {32'h04568787, 32'hAC786425, 32'h0F986550};
  localparam logic [95:0] PAY2 = {32'h11112222, 32'h33334444, 32'h55556666};

  get_digests_requester #(.TIMEOUT(4), .MAX_RETRIES(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .req_header(req_header),
    .req_valid(req_valid), .rsp_ack_in(rsp_ack_in), .rsp_header(rsp_header),
    .rsp_payload(rsp_payload), .digests(digests), .slot_mask(slot_mask),
    .digests_valid(digests_valid), .done(done), .error(error),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // start in cycle 0, ack visible in cycle 3, outcome in cycle 5
  task automatic xact(input logic [31:0] hdr, input logic [95:0] pay, input logic [2:0] code,
                      input logic [7:0] mask, input bit poke);
    rsp_header = hdr;
    rsp_payload = pay;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("send_rv", req_valid, 0);
    chk("send_busy", busy, 1);
    chk("req_hdr", req_header, 32'h01810000);
    tick();
    chk("wait_rv", req_valid, 1);
    start = poke;
    tick();
    start = 1'b0;
    chk("ack_cyc_rv", req_valid, 1);
    rsp_ack_in = 1'b1;
    tick();
    rsp_ack_in = 1'b0;
    chk("check_rv", req_valid, 0);
    tick();
    if (code == 3'd0) begin
      chk("done", done, 1);
      chk("digests", digests, pay);
      chk("slot_mask", slot_mask, mask);
      chk("dv", digests_valid, 1);
      chk("code0", err_code, 0);
    end else begin
      chk("error", error, 1);
      chk("done_low", done, 0);
      chk("code", err_code, code);
      chk("dv_low", digests_valid, 0);
    end
    tick();
    chk("idle_busy", busy, 0);
    chk("pulse_done", done, 0);
    chk("pulse_err", error, 0);
    chk("code_held", err_code, code);
    chk("hdr_idle", req_header, 0);
  endtask

  initial begin
    int hi, rises;
    logic prev;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rv", req_valid, 0);
    chk("rst_hdr", req_header, 0);
    chk("rst_dig", digests, 0);
    chk("rst_flags", {digests_valid, done, error, err_code}, 0);
    reset_n = 1'b1;
    tick();
    xact(32'h01010001, PAY, 3'd0, 8'h01, 1'b1);
    xact(32'h02010001, PAY2, 3'd1, 8'h00, 1'b0);
    xact(32'h02810001, PAY2, 3'd1, 8'h00, 1'b0);
    xact(32'h01810001, PAY2, 3'd2, 8'h00, 1'b0);
    xact(32'h01010100, PAY2, 3'd3, 8'h00, 1'b0);
    xact(32'h010100A5, PAY2, 3'd0, 8'hA5, 1'b0);
    // three bursts of 5, gaps of 1, no ack
    start = 1'b1;
    tick();
    start = 1'b0;
    hi = 0;
    rises = 0;
    prev = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (req_valid) hi++;
      if (req_valid && !prev) rises++;
      prev = req_valid;
      tick();
    end
    chk("tmo_hi", hi, 15);
    chk("tmo_bursts", rises, 3);
    chk("tmo_err", error, 1);
    chk("tmo_code", err_code, 4);
    tick();
    chk("tmo_idle", busy, 0);
    // ack during second burst
    rsp_header = 32'h01010003;
    rsp_payload = PAY;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("gap_rv", req_valid, 0);
    tick();
    chk("burst2_rv", req_valid, 1);
    tick();
    rsp_ack_in = 1'b1;
    tick();
    rsp_ack_in = 1'b0;
    chk("b2_check_rv", req_valid, 0);
    tick();
    chk("b2_done", done, 1);
    chk("b2_code", err_code, 0);
    chk("b2_mask", slot_mask, 8'h03);
    tick();
    // reset in WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_rv", req_valid, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_rv", req_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dig", digests, 0);
    chk("mid_rst_flags", {digests_valid, done, error, err_code, slot_mask}, 0);
    rsp_ack_in = 1'b1;
    tick();
    tick();
    rsp_ack_in = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_rv", req_valid, 0);
    chk("stray_flags", {digests_valid, done, error, err_code}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/get_digests_requester.md
# get_digests_requester

Initiator side of the GET_DIGESTS exchange in the USB Type-C authentication driver. It builds and presents the GET_DIGESTS request header and holds the request-valid handshake until the responder acknowledges. It then captures the DIGESTS answer (header plus payload) and checks the header fields. It reports either the captured digests or an error code, and retries on timeout.

## Interface
Parameters:
- HDR_W, 32: header width; fields are version [31:24], command [23:16], param1 [15:8], param2 [7:0].
- PAY_W, 96: payload width, three 32-bit digest words.
- PROTO_VER, 8'h01: expected and transmitted protocol version.
- REQ_CMD, 8'h81: GET_DIGESTS request code.
- RSP_CMD, 8'h01: DIGESTS answer code.
- TIMEOUT, 255: WAIT cycles before an attempt is abandoned; 8-bit counter.
- MAX_RETRIES, 2: re-sends allowed after the first attempt.

Ports (one clock; reset is synchronous, active-low):
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: synchronous active-low reset.
- start, input, 1: request a transaction; sampled only in IDLE.
- req_header, output, HDR_W: {PROTO_VER, REQ_CMD, 8'h00, 8'h00} while busy, 0 otherwise.
- req_valid, output, 1: request handshake, driven into the responder's Ack_in.
- rsp_ack_in, input, 1: responder's Ack_out.
- rsp_header, input, HDR_W: answer header.
- rsp_payload, input, PAY_W: answer payload.
- digests, output, PAY_W: captured payload; valid while digests_valid=1.
- slot_mask, output, 8: captured param2 (cert-chain mask).
- digests_valid, output, 1: level signal; set on success, cleared on start or reset.
- done, output, 1: one-cycle success pulse.
- error, output, 1: one-cycle failure pulse.
- err_code, output, 3: 0 none, 1 bad version, 2 bad command, 3 empty slot mask, 4 timeout. Held until next start.
- busy, output, 1: high whenever the FSM is not in IDLE.

## Operation
- All outputs are registered. After reset every output is 0 and the state is IDLE.
- FSM states: IDLE, SEND, WAIT, CHECK, DONE, ERR.
- IDLE:
  - start=1 moves to SEND.
  - On start, clear digests_valid, err_code and the retry counter.
- SEND:
  - One-cycle setup state with req_valid=0.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - req_valid=1; the counter increments each cycle.
  - rsp_ack_in=1 captures rsp_header and rsp_payload into internal registers, drops req_valid, and goes to CHECK.
  - If the counter reaches TIMEOUT with no ack and retries < MAX_RETRIES: increment retries and go to SEND. This produces a one-cycle req_valid=0 gap.
  - If the counter reaches TIMEOUT with retries exhausted: err_code=4, go to ERR.
- CHECK (priority order):
  - version ≠ PROTO_VER gives code 1.
  - command ≠ RSP_CMD gives code 2.
  - param2 == 0 gives code 3.
  - Any failure goes to ERR. Success loads digests and slot_mask, sets digests_valid, and goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error=1 for one cycle, then IDLE.
- rsp_ack_in is ignored outside WAIT.
- start is ignored while busy.
- If an ack and the timeout terminal count occur in the same cycle, the ack wins.
- reset_n=0 in any state returns to IDLE at the next edge and clears all outputs and counters.

## Timing
- The start edge is cycle 0.
  - SEND in cycle 1.
  - WAIT with req_valid=1 from cycle 2.
- With a registered responder:
  - The ack is visible in cycle 3.
  - Capture happens at edge 4, giving CHECK in cycle 4.
  - done is high in cycle 5; busy falls in cycle 6.
  - Start-to-done latency is 5 cycles.
- Timeout: an attempt with no ack spends TIMEOUT+1 cycles in WAIT.
  - The worst case is (MAX_RETRIES+1) × (TIMEOUT+2) cycles before the error pulse.
- req_valid remains high in every WAIT cycle, including the cycle rsp_ack_in is sampled. It is low from the next cycle.

## Test plan
- Normal answer: start=1 with the responder returning header 32'h01010001 and payload {32'h04568787, 32'hAC786425, 32'h0F986550}. Required: done in cycle 5, digests equals that payload, slot_mask=8'h01, digests_valid=1, err_code=0.
- Bad version: answer header 32'h02010001. Required: error pulse, err_code=1, digests_valid=0. A header that is wrong in both version and command (32'h02810001) still reports code 1.
- Empty mask: answer header 32'h01010100. Required: err_code=3.
- Timeout with TIMEOUT=4 and MAX_RETRIES=2, no ack: three req_valid bursts of 5 cycles each, separated by 1-cycle gaps. Required: then error with err_code=4. In a second run, an ack during the second burst yields done.
- Reset mid-WAIT: reset_n=0 for one cycle. Required: req_valid, busy and all outputs are 0 at the next edge. A stray rsp_ack_in while in IDLE has no effect. A start pulse while busy is ignored.
